// File: rtl/polilock_pkg.sv
// Constants shared by the Polilock blocks: keypad ASCII codes, function
// encodings and the frame-parser state codes.
package polilock_pkg;

    localparam logic [7:0] ASCII_V    = 8'h56;
    localparam logic [7:0] ASCII_C    = 8'h43;
    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_STAR = 8'h2A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;

    localparam logic [1:0] FUNCAO_NENHUMA      = 2'b00;
    localparam logic [1:0] FUNCAO_VERIFICACAO  = 2'b01;
    localparam logic [1:0] FUNCAO_CONFIGURACAO = 2'b10;

    localparam logic [2:0] ESTADO_OCIOSO     = 3'd0;
    localparam logic [2:0] ESTADO_DIGITOS    = 3'd1;
    localparam logic [2:0] ESTADO_TERMINADOR = 3'd2;
    localparam logic [2:0] ESTADO_ENTREGA    = 3'd3;
    localparam logic [2:0] ESTADO_ERRO       = 3'd4;

    function automatic logic eh_digito(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/carregador_senha_buffer_digitos.sv
// Entry-digit buffer: a shadow copy filled while a frame is parsed and a
// committed copy, updated only on commit, read asynchronously by the datapath.
module buffer_digitos #(
    parameter int N_DIGITOS = 4,
    parameter int W_END     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             escreve,
    input  logic [W_END:0]   endereco_escrita,
    input  logic [3:0]       dado_escrito,
    input  logic             confirma,
    input  logic [W_END-1:0] endereco_leitura,
    output logic [3:0]       dado_lido
);

    logic [3:0] sombra_q      [N_DIGITOS];
    logic [3:0] sombra_d      [N_DIGITOS];
    logic [3:0] confirmado_q  [N_DIGITOS];
    logic [3:0] confirmado_d  [N_DIGITOS];

    always_comb begin
        sombra_d     = sombra_q;
        confirmado_d = confirmado_q;
        for (int unsigned i = 0; i < N_DIGITOS; i++) begin
            if (escreve && (endereco_escrita == i[W_END:0])) begin
                sombra_d[i] = dado_escrito;
            end
        end
        // Commit copies the registered shadow: the last digit was written on an earlier edge.
        if (confirma) begin
            confirmado_d = sombra_q;
        end
    end

    always_comb begin
        dado_lido = '0;
        for (int unsigned i = 0; i < N_DIGITOS; i++) begin
            if (endereco_leitura == i[W_END-1:0]) begin
                dado_lido = confirmado_q[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sombra_q     <= '{default: '0};
            confirmado_q <= '{default: '0};
        end else begin
            sombra_q     <= sombra_d;
            confirmado_q <= confirmado_d;
        end
    end

endmodule

// File: rtl/carregador_senha.sv
// Frame parser for the Polilock keypad: "<V|C><digits>#" is checked character
// by character and committed atomically into the entry-digit buffer.
module carregador_senha
    import polilock_pkg::*;
#(
    parameter int N_DIGITOS = 4,
    parameter int W_END     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             char_valido,
    input  logic [7:0]       char,
    output logic             char_pronto,
    input  logic             bloqueado,
    input  logic [W_END-1:0] endereco,
    output logic [3:0]       dado_lido,
    output logic [1:0]       funcao,
    output logic             funcao_selecionada,
    output logic             erro_quadro,
    output logic [2:0]       db_estado
);

    localparam logic [W_END:0] CONT_ULTIMO = (W_END + 1)'(N_DIGITOS - 1);

    logic [2:0]     estado_q, estado_d;
    logic [W_END:0] cont_q, cont_d;
    logic [1:0]     funcao_pend_q, funcao_pend_d;
    logic [1:0]     funcao_q, funcao_d;
    logic           transferencia;
    logic           escreve;
    logic           confirma;

    assign char_pronto = !bloqueado && ((estado_q == ESTADO_OCIOSO) ||
                                        (estado_q == ESTADO_DIGITOS) ||
                                        (estado_q == ESTADO_TERMINADOR));
    assign transferencia      = char_valido && char_pronto;
    assign funcao_selecionada = (estado_q == ESTADO_ENTREGA);
    assign erro_quadro        = (estado_q == ESTADO_ERRO);
    assign funcao             = funcao_q;
    assign db_estado          = estado_q;

    always_comb begin
        estado_d      = estado_q;
        cont_d        = cont_q;
        funcao_pend_d = funcao_pend_q;
        funcao_d      = funcao_q;
        escreve       = 1'b0;
        confirma      = 1'b0;
        if (bloqueado) begin
            estado_d = ESTADO_OCIOSO;
        end else begin
            case (estado_q)
                ESTADO_OCIOSO: begin
                    if (transferencia && (char == ASCII_V || char == ASCII_C)) begin
                        funcao_pend_d = (char == ASCII_V) ? FUNCAO_VERIFICACAO : FUNCAO_CONFIGURACAO;
                        cont_d        = '0;
                        estado_d      = ESTADO_DIGITOS;
                    end
                end
                ESTADO_DIGITOS: begin
                    if (transferencia) begin
                        if (char == ASCII_STAR) begin
                            estado_d = ESTADO_OCIOSO;
                        end else if (eh_digito(char)) begin
                            escreve  = 1'b1;
                            cont_d   = cont_q + 1'b1;
                            estado_d = (cont_q == CONT_ULTIMO) ? ESTADO_TERMINADOR : ESTADO_DIGITOS;
                        end else begin
                            estado_d = ESTADO_ERRO;
                        end
                    end
                end
                ESTADO_TERMINADOR: begin
                    if (transferencia) begin
                        if (char == ASCII_HASH) begin
                            confirma = 1'b1;
                            funcao_d = funcao_pend_q;
                            estado_d = ESTADO_ENTREGA;
                        end else if (char == ASCII_STAR) begin
                            estado_d = ESTADO_OCIOSO;
                        end else begin
                            estado_d = ESTADO_ERRO;
                        end
                    end
                end
                default: estado_d = ESTADO_OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q      <= ESTADO_OCIOSO;
            cont_q        <= '0;
            funcao_pend_q <= FUNCAO_NENHUMA;
            funcao_q      <= FUNCAO_NENHUMA;
        end else begin
            estado_q      <= estado_d;
            cont_q        <= cont_d;
            funcao_pend_q <= funcao_pend_d;
            funcao_q      <= funcao_d;
        end
    end

    // ASCII digits carry their value in the low nibble.
    buffer_digitos #(
        .N_DIGITOS (N_DIGITOS),
        .W_END     (W_END)
    ) u_buffer (
        .clock            (clock),
        .reset            (reset),
        .escreve          (escreve),
        .endereco_escrita (cont_q),
        .dado_escrito     (char[3:0]),
        .confirma         (confirma),
        .endereco_leitura (endereco),
        .dado_lido        (dado_lido)
    );

endmodule

// File: tb/tb_carregador_senha.sv
// Bench for carregador_senha: directed frames from the test plan followed by
// random traffic, all compared against a frame-level reference model.
module tb_carregador_senha;

    localparam int N = 4;
    localparam int W = 2;

    logic         clock;
    logic         reset;
    logic         char_valido;
    logic [7:0]   char_in;
    logic         char_pronto;
    logic         bloqueado;
    logic [W-1:0] endereco;
    logic [3:0]   dado_lido;
    logic [1:0]   funcao;
    logic         funcao_selecionada;
    logic         erro_quadro;
    logic [2:0]   db_estado;

    carregador_senha #(.N_DIGITOS(N), .W_END(W)) dut (
        .clock              (clock),
        .reset              (reset),
        .char_valido        (char_valido),
        .char               (char_in),
        .char_pronto        (char_pronto),
        .bloqueado          (bloqueado),
        .endereco           (endereco),
        .dado_lido          (dado_lido),
        .funcao             (funcao),
        .funcao_selecionada (funcao_selecionada),
        .erro_quadro        (erro_quadro),
        .db_estado          (db_estado)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: the accepted characters of the open frame, the
    // committed digits/function, and which one-cycle pulse (if any) is due.
    logic [7:0] m_frame[$];
    logic [3:0] m_buf [N];
    logic [1:0] m_fun;
    bit         m_sel;
    bit         m_err;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return !m_sel && !m_err;
    endfunction

    function automatic logic [2:0] m_estado();
        if (m_sel) return 3'd3;
        if (m_err) return 3'd4;
        if (m_frame.size() == 0) return 3'd0;
        if (m_frame.size() <= N) return 3'd1;
        return 3'd2;
    endfunction

    task automatic m_reset();
        m_frame.delete();
        for (int i = 0; i < N; i++) m_buf[i] = 4'd0;
        m_fun = 2'b00;
        m_sel = 0;
        m_err = 0;
    endtask

    task automatic model_edge(input bit acc, input logic [7:0] c, input bit blk);
        bit was_pulse;
        was_pulse = m_sel || m_err;
        m_sel = 0;
        m_err = 0;
        if (blk) begin
            m_frame.delete();
        end else if (!was_pulse && acc) begin
            if (m_frame.size() == 0) begin
                if (c == "V" || c == "C") m_frame.push_back(c);
            end else if (c == "*") begin
                m_frame.delete();
            end else if (m_frame.size() <= N) begin
                if (c >= "0" && c <= "9") m_frame.push_back(c);
                else begin
                    m_frame.delete();
                    m_err = 1;
                end
            end else if (c == "#") begin
                for (int i = 0; i < N; i++) m_buf[i] = 4'(m_frame[i+1] - 8'h30);
                m_fun = (m_frame[0] == "V") ? 2'b01 : 2'b10;
                m_frame.delete();
                m_sel = 1;
            end else begin
                m_frame.delete();
                m_err = 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".funcao_selecionada"}, 8'(funcao_selecionada), 8'(m_sel));
        chk({tag, ".erro_quadro"}, 8'(erro_quadro), 8'(m_err));
        chk({tag, ".funcao"}, 8'(funcao), 8'(m_fun));
        chk({tag, ".db_estado"}, 8'(db_estado), 8'(m_estado()));
        chk({tag, ".char_pronto"}, 8'(char_pronto), 8'(!bloqueado && m_ready()));
        for (int a = 0; a < 4; a++) begin
            endereco = W'(a);
            #1;
            chk({tag, ".dado_lido"}, 8'(dado_lido), 8'((a < N) ? m_buf[a] : 4'd0));
        end
    endtask

    task automatic cycle(input bit v, input logic [7:0] c, input bit blk, input string tag);
        bit acc;
        @(negedge clock);
        char_valido = v;
        char_in     = c;
        bloqueado   = blk;
        #1;
        chk({tag, ".char_pronto_now"}, 8'(char_pronto), 8'(!blk && m_ready()));
        acc = v && !blk && m_ready();
        @(posedge clock);
        model_edge(acc, c, blk);
        #1;
        check_outputs(tag);
    endtask

    task automatic send_str(input string s, input string tag);
        int guard;
        for (int i = 0; i < s.len(); i++) begin
            guard = 0;
            while (!m_ready() && guard < 4) begin
                cycle(0, 8'h00, 0, tag);
                guard++;
            end
            cycle(1, s[i], 0, tag);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset       = 1'b1;
        char_valido = 1'b0;
        #1;
        m_reset();
        check_outputs(tag);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [7:0] rand_char();
        int r;
        r = $urandom_range(0, 99);
        if (r < 40) return 8'(8'h30 + $urandom_range(0, 9));
        if (r < 55) return "#";
        if (r < 65) return "V";
        if (r < 75) return "C";
        if (r < 80) return "*";
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        reset       = 1'b1;
        char_valido = 1'b0;
        char_in     = 8'h00;
        bloqueado   = 1'b0;
        endereco    = '0;
        m_reset();
        #3;
        check_outputs("reset");
        bloqueado = 1'b1;
        #1;
        chk("reset.char_pronto_blk", 8'(char_pronto), 8'h00);
        bloqueado = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        send_str("V1234#", "v1234");
        cycle(0, 8'h00, 0, "v1234.pulse_end");
        send_str("C9870#", "c9870");
        cycle(0, 8'h00, 0, "c9870.pulse_end");
        send_str("V12a", "v12a");
        cycle(0, 8'h00, 0, "v12a.err_end");
        send_str("V12*", "v12star");
        send_str("V5555#", "v5555");
        cycle(0, 8'h00, 0, "v5555.pulse_end");
        send_str("C12", "c12");
        cycle(0, 8'h00, 1, "c12.blk");
        cycle(0, 8'h00, 0, "c12.unblk");
        cycle(1, "#", 0, "c12.hash_idle");
        send_str("V123", "v123");
        do_reset("v123.reset");
        send_str("V0001#", "v0001");
        cycle(0, 8'h00, 0, "v0001.pulse_end");

        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                logic [7:0] fr[$];
                fr.push_back(($urandom_range(0, 1) == 1) ? "V" : "C");
                for (int d = 0; d < N; d++) fr.push_back(8'(8'h30 + $urandom_range(0, 9)));
                fr.push_back("#");
                for (int k = 0; k < fr.size(); k++) begin
                    if ($urandom_range(0, 4) == 0) cycle(0, rand_char(), 0, "rnd.gap");
                    while (!m_ready()) cycle(0, 8'h00, 0, "rnd.wait");
                    cycle(1, fr[k], 0, "rnd.frame");
                end
            end else begin
                int len;
                len = $urandom_range(1, 8);
                for (int k = 0; k < len; k++) begin
                    cycle($urandom_range(0, 3) != 0, rand_char(),
                          $urandom_range(0, 19) == 0, "rnd.noise");
                end
            end
            if (it == 30) do_reset("rnd.reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
